// File: rtl/sa_fifo_rwsthp_80x17_ctrl_if.sv
// Valid/ready stream bundle between the producer/consumer and the FIFO controller.
// The controller takes the slave side; occupancy travels with the streams.
interface sa_fifo_rwsthp_80x17_ctrl_if #(
  parameter int WIDTH = 17,
  parameter int CW    = 7
);
  logic             wr_pvld;
  logic             wr_prdy;
  logic [WIDTH-1:0] wr_pd;
  logic             rd_pvld;
  logic             rd_prdy;
  logic [WIDTH-1:0] rd_pd;
  logic [CW-1:0]    occ;

  modport master (
    output wr_pvld, wr_pd, rd_prdy,
    input  wr_prdy, rd_pvld, rd_pd, occ
  );

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy,
    output wr_prdy, rd_pvld, rd_pd, occ
  );
endinterface

// File: rtl/sa_fifo_rwsthp_80x17_ctrl.sv
// FIFO controller for an external 80x17 two-port RAM with a registered read address
// and a registered output; keeps a 1 word/cycle valid/ready stream on both sides.
module sa_fifo_rwsthp_80x17_ctrl #(
  parameter int DEPTH = 80,
  parameter int WIDTH = 17,
  parameter int AW    = 7,
  parameter int CW    = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  sa_fifo_rwsthp_80x17_ctrl_if.slave    fifo,
  output logic [AW-1:0]                 ram_wa,
  output logic                          ram_we,
  output logic [WIDTH-1:0]              ram_di,
  output logic [AW-1:0]                 ram_ra,
  output logic                          ram_re,
  output logic                          ram_ore,
  input  logic [WIDTH-1:0]              ram_dout,
  output logic                          ram_byp_sel,
  output logic [WIDTH-1:0]              ram_dbyp,
  input  logic [31:0]                   pwrbus_ram_pd,
  output logic [31:0]                   ram_pwrbus_ram_pd
);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] ram_cnt;
  logic [CW-1:0] held;
  logic          s1_vld;
  logic          s2_vld;

  logic          wr_prdy;
  logic          wr_acc;
  logic          adv1;
  logic          issue;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // held also covers the word whose address sits in the RAM read register,
  // so a slot cannot be overwritten before its data reaches the output register.
  always_comb begin
    wr_prdy = 1'b0;
    wr_acc  = 1'b0;
    adv1    = 1'b0;
    issue   = 1'b0;
    if (!rst) begin
      wr_prdy = (held < CW'(DEPTH));
      wr_acc  = fifo.wr_pvld && wr_prdy;
      adv1    = s1_vld && (!s2_vld || fifo.rd_prdy);
      issue   = (ram_cnt != '0) && (!s1_vld || adv1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      held    <= '0;
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= ptr_inc(wptr);
      end
      if (issue) begin
        rptr <= ptr_inc(rptr);
      end

      case ({wr_acc, issue})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase

      case ({wr_acc, adv1})
        2'b10:   held <= held + 1'b1;
        2'b01:   held <= held - 1'b1;
        default: held <= held;
      endcase

      s1_vld <= issue || (s1_vld && !adv1);
      s2_vld <= adv1 || (s2_vld && !fifo.rd_prdy);
    end
  end

  // Output register only loads on adv1, which is what holds rd_pd under backpressure.
  always_comb begin
    fifo.wr_prdy      = wr_prdy;
    fifo.rd_pvld      = s2_vld && !rst;
    fifo.rd_pd        = ram_dout;
    fifo.occ          = rst ? '0 : held + CW'(s2_vld);
    ram_we            = wr_acc;
    ram_wa            = wptr;
    ram_di            = fifo.wr_pd;
    ram_re            = issue;
    ram_ra            = rptr;
    ram_ore           = adv1;
    ram_byp_sel       = 1'b0;
    ram_dbyp          = '0;
    ram_pwrbus_ram_pd = pwrbus_ram_pd;
  end

endmodule

// File: tb/tb_sa_fifo_rwsthp_80x17_ctrl.sv
// Scoreboard bench for the 80x17 FIFO controller with a behavioural model of the
// external RAM (registered read address, output register loaded by ore).
module tb_sa_fifo_rwsthp_80x17_ctrl;

  logic        clk;
  logic        rst;
  logic [6:0]  ram_wa;
  logic        ram_we;
  logic [16:0] ram_di;
  logic [6:0]  ram_ra;
  logic        ram_re;
  logic        ram_ore;
  logic [16:0] ram_dout;
  logic        ram_byp_sel;
  logic [16:0] ram_dbyp;
  logic [31:0] pwrbus_ram_pd;
  logic [31:0] ram_pwrbus_ram_pd;

  sa_fifo_rwsthp_80x17_ctrl_if bus ();

  sa_fifo_rwsthp_80x17_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .fifo              (bus),
    .ram_wa            (ram_wa),
    .ram_we            (ram_we),
    .ram_di            (ram_di),
    .ram_ra            (ram_ra),
    .ram_re            (ram_re),
    .ram_ore           (ram_ore),
    .ram_dout          (ram_dout),
    .ram_byp_sel       (ram_byp_sel),
    .ram_dbyp          (ram_dbyp),
    .pwrbus_ram_pd     (pwrbus_ram_pd),
    .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] mem [0:79];
  logic [6:0]  ra_q;

  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
    if (ram_ore) ram_dout <= mem[ra_q];
  end

  int          check_count = 0;
  int          err_count   = 0;
  logic [16:0] sb [$];
  int          exp_wa = 0;
  int          exp_ra = 0;
  int          pop_count = 0;
  logic [16:0] last_pop = '0;
  logic        hold_pending = 1'b0;
  logic [16:0] hold_val = '0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [16:0] d, input logic rr);
    @(posedge clk);
    #1;
    bus.wr_pvld = wv;
    bus.wr_pd   = d;
    bus.rd_prdy = rr;
  endtask

  task automatic sampleCycle();
    @(negedge clk);
    #2;
  endtask

  task automatic drainAll(input int budget);
    for (int c = 0; c < budget && sb.size() != 0; c++) begin
      applyStimulus(1'b0, 17'h0, 1'b1);
      sampleCycle();
    end
    checkOutput("drain_empty", sb.size(), 0);
  endtask

  // Scoreboard monitor: occupancy equals words accepted and not yet popped.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      sb.delete();
      exp_wa = 0;
      exp_ra = 0;
      hold_pending = 1'b0;
    end else begin
      checkOutput("occ", 32'(bus.occ), sb.size());
      if (hold_pending) begin
        checkOutput("hold_vld", 32'(bus.rd_pvld), 1);
        checkOutput("hold_pd", 32'(bus.rd_pd), 32'(hold_val));
      end
      checkOutput("ram_we", 32'(ram_we), 32'(bus.wr_pvld && bus.wr_prdy));
      if (ram_we) begin
        checkOutput("ram_wa", 32'(ram_wa), exp_wa);
        checkOutput("ram_di", 32'(ram_di), 32'(bus.wr_pd));
        exp_wa = (exp_wa == 79) ? 0 : exp_wa + 1;
      end
      if (ram_re) begin
        checkOutput("ram_ra", 32'(ram_ra), exp_ra);
        exp_ra = (exp_ra == 79) ? 0 : exp_ra + 1;
      end
      if (bus.wr_pvld && bus.wr_prdy) sb.push_back(bus.wr_pd);
      if (bus.rd_pvld && bus.rd_prdy) begin
        if (sb.size() == 0) begin
          checkOutput("rd_unexpected", 32'(bus.rd_pvld), 0);
        end else begin
          last_pop = sb.pop_front();
          checkOutput("rd_pd", 32'(bus.rd_pd), 32'(last_pop));
          pop_count++;
        end
      end
      hold_pending = bus.rd_pvld && !bus.rd_prdy;
      hold_val     = bus.rd_pd;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", err_count + 1, check_count + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int next;
    int iters;
    int stalls;
    int pops_before;

    rst           = 1'b1;
    bus.wr_pvld   = 1'b0;
    bus.wr_pd     = '0;
    bus.rd_prdy   = 1'b0;
    pwrbus_ram_pd = 32'hA5C3_0F12;

    // Reset state
    repeat (2) @(posedge clk);
    sampleCycle();
    checkOutput("rst_wr_prdy", 32'(bus.wr_prdy), 0);
    checkOutput("rst_rd_pvld", 32'(bus.rd_pvld), 0);
    checkOutput("rst_occ", 32'(bus.occ), 0);
    checkOutput("rst_ram_we", 32'(ram_we), 0);
    checkOutput("rst_ram_re", 32'(ram_re), 0);
    checkOutput("rst_ram_ore", 32'(ram_ore), 0);
    checkOutput("byp_sel", 32'(ram_byp_sel), 0);
    checkOutput("dbyp", 32'(ram_dbyp), 0);
    checkOutput("pwrbus", ram_pwrbus_ram_pd, 32'hA5C3_0F12);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sampleCycle();
    checkOutput("post_rst_wr_prdy", 32'(bus.wr_prdy), 1);

    // Single word: re the next cycle, ore after that, valid three cycles after accept
    applyStimulus(1'b1, 17'h1A5A5, 1'b1);
    sampleCycle();
    checkOutput("single_we", 32'(ram_we), 1);
    checkOutput("single_wa", 32'(ram_wa), 0);
    applyStimulus(1'b0, 17'h0, 1'b1);
    sampleCycle();
    checkOutput("single_re", 32'(ram_re), 1);
    checkOutput("single_ra", 32'(ram_ra), 0);
    checkOutput("single_vld_c1", 32'(bus.rd_pvld), 0);
    applyStimulus(1'b0, 17'h0, 1'b1);
    sampleCycle();
    checkOutput("single_ore", 32'(ram_ore), 1);
    checkOutput("single_vld_c2", 32'(bus.rd_pvld), 0);
    applyStimulus(1'b0, 17'h0, 1'b1);
    sampleCycle();
    checkOutput("single_vld_c3", 32'(bus.rd_pvld), 1);
    checkOutput("single_pd", 32'(bus.rd_pd), 32'h1A5A5);
    checkOutput("single_occ1", 32'(bus.occ), 1);
    applyStimulus(1'b0, 17'h0, 1'b1);
    sampleCycle();
    checkOutput("single_vld_after", 32'(bus.rd_pvld), 0);
    checkOutput("single_occ0", 32'(bus.occ), 0);

    // Fill with the consumer stalled: 80 in RAM (incl. the s1 slot) plus one in the output register
    next = 0;
    for (int c = 0; c < 120; c++) begin
      applyStimulus(1'b1, 17'(next), 1'b0);
      sampleCycle();
      if (bus.wr_prdy) next++;
    end
    applyStimulus(1'b0, 17'h0, 1'b0);
    sampleCycle();
    checkOutput("fill_accepted", next, 81);
    checkOutput("fill_occ", 32'(bus.occ), 81);
    checkOutput("fill_wr_prdy", 32'(bus.wr_prdy), 0);
    checkOutput("fill_head", 32'(bus.rd_pd), 0);

    iters = 0;
    for (int c = 0; c < 300 && sb.size() != 0; c++) begin
      applyStimulus(1'b0, 17'h0, 1'b1);
      sampleCycle();
      iters++;
    end
    checkOutput("fill_drain_cycles", iters, 81);
    checkOutput("fill_drain_empty", sb.size(), 0);

    // Continuous streaming across pointer wrap
    pops_before = pop_count;
    stalls = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1, 17'(i * 7 + 3), 1'b1);
      sampleCycle();
      if (!bus.wr_prdy) stalls++;
    end
    checkOutput("stream_stalls", stalls, 0);
    checkOutput("stream_pops", pop_count - pops_before, 197);
    drainAll(20);

    // Random traffic with random backpressure
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 99) < 70, 17'($urandom), 1'($urandom));
      sampleCycle();
    end
    drainAll(300);

    // Write offered at full while a pop happens: refused now, taken the next cycle
    next = 0;
    for (int c = 0; c < 150; c++) begin
      applyStimulus(1'b1, 17'(1000 + next), 1'b0);
      sampleCycle();
      if (!bus.wr_prdy) break;
      next++;
    end
    checkOutput("full_occ", 32'(bus.occ), 81);
    applyStimulus(1'b1, 17'h0ABCD, 1'b1);
    sampleCycle();
    checkOutput("full_no_write", 32'(bus.wr_prdy), 0);
    checkOutput("full_vld", 32'(bus.rd_pvld), 1);
    applyStimulus(1'b1, 17'h0ABCD, 1'b1);
    sampleCycle();
    checkOutput("full_write_next", 32'(bus.wr_prdy), 1);
    checkOutput("full_occ_after", 32'(bus.occ), 80);

    // Reset with 40 words held
    for (int c = 0; c < 100 && sb.size() > 40; c++) begin
      applyStimulus(1'b0, 17'h0, 1'b1);
      sampleCycle();
    end
    checkOutput("pre_rst_level", sb.size(), 40);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.wr_pvld = 1'b0;
    bus.rd_prdy = 1'b0;
    sampleCycle();
    checkOutput("mid_rst_vld", 32'(bus.rd_pvld), 0);
    checkOutput("mid_rst_occ", 32'(bus.occ), 0);
    checkOutput("mid_rst_prdy", 32'(bus.wr_prdy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sampleCycle();
    checkOutput("after_rst_vld", 32'(bus.rd_pvld), 0);
    checkOutput("after_rst_occ", 32'(bus.occ), 0);
    checkOutput("after_rst_prdy", 32'(bus.wr_prdy), 1);
    pops_before = pop_count;
    applyStimulus(1'b1, 17'h00001, 1'b1);
    sampleCycle();
    for (int c = 0; c < 10 && pop_count == pops_before; c++) begin
      applyStimulus(1'b0, 17'h0, 1'b1);
      sampleCycle();
    end
    checkOutput("after_rst_popped", pop_count - pops_before, 1);
    checkOutput("after_rst_first", 32'(last_pop), 32'h00001);
    drainAll(10);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
